// File: rtl/conv_window_feeder.sv
// conv_window_feeder: collects a serial sample stream into a sliding
// INPUT_LAYER_HEIGHT x KERNEL_WIDTH window. Each time the window holds a full
// set of columns it pulses start_o to the layer. The window then stays frozen
// until the layer reports done. The design requires INPUT_LAYER_HEIGHT >= 2.
module conv_window_feeder #(
  parameter int INPUT_LAYER_HEIGHT = 4,
  parameter int KERNEL_WIDTH       = 2,
  parameter int WORD_SIZE          = 16
) (
  input  logic                                                      clk_i,
  input  logic                                                      reset_i,
  input  logic                                                      flush_i,
  input  logic                                                      valid_i,
  input  logic [WORD_SIZE-1:0]                                      data_i,
  output logic                                                      ready_o,
  output logic                                                      start_o,
  input  logic                                                      done_i,
  output logic [INPUT_LAYER_HEIGHT-1:0][KERNEL_WIDTH-1:0][WORD_SIZE-1:0] window_o,
  output logic                                                      busy_o
);

  localparam int H  = INPUT_LAYER_HEIGHT;
  localparam int K  = KERNEL_WIDTH;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int FW = $clog2(K + 1);

  typedef enum logic [1:0] {eFILL, eSTART, eSETTLE, eWAIT} state_t;

  state_t                                     state_q, state_d;
  logic [RW-1:0]                              row_q;
  logic [FW-1:0]                              fill_q;
  logic [H-2:0][WORD_SIZE-1:0]                staging_q;
  logic [H-1:0][K-1:0][WORD_SIZE-1:0]         window_q;

  logic in_fill;
  logic accept;
  logic last_row;

  assign in_fill  = (state_q == eFILL);
  // A flush in eFILL wins over a simultaneous word, which is then dropped.
  assign accept   = in_fill && valid_i && !flush_i;
  assign last_row = (row_q == RW'(H - 1));
  assign window_o = window_q;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= eFILL;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    start_o = 1'b0;
    busy_o  = 1'b1;
    case (state_q)
      eFILL: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (accept && last_row && (fill_q >= FW'(K - 1))) state_d = eSTART;
      end
      eSTART: begin
        start_o = 1'b1;
        state_d = eSETTLE;
      end
      // The layer's done only drops one cycle after start, so it is ignored here.
      eSETTLE: state_d = eWAIT;
      eWAIT: begin
        if (done_i) state_d = eFILL;
      end
      default: state_d = eFILL;
    endcase
  end

  // Row counter, fill count, staging column and window shift.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_q     <= '0;
      fill_q    <= '0;
      staging_q <= '0;
      window_q  <= '0;
    end else if (in_fill && flush_i) begin
      row_q  <= '0;
      fill_q <= '0;
    end else if (accept) begin
      if (last_row) begin
        for (int unsigned h = 0; h < H; h++) begin
          for (int unsigned w = 0; w + 1 < K; w++) begin
            window_q[h][w] <= window_q[h][w+1];
          end
        end
        for (int unsigned h = 0; h + 1 < H; h++) begin
          window_q[h][K-1] <= staging_q[h];
        end
        window_q[H-1][K-1] <= data_i;
        row_q <= '0;
        if (fill_q != FW'(K)) fill_q <= fill_q + FW'(1);
      end else begin
        staging_q[row_q] <= data_i;
        row_q            <= row_q + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: directed sequences with random data and gaps,
// checked against a column-history reference model.
module tb_conv_window_feeder;

  localparam int H = 4;
  localparam int K = 2;
  localparam int W = 16;

  typedef logic [H-1:0][W-1:0]         col_t;
  typedef logic [H-1:0][K-1:0][W-1:0]  win_t;

  logic         clk_i   = 1'b0;
  logic         reset_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i  = '0;
  logic         done_i  = 1'b1;
  logic         ready_o;
  logic         start_o;
  logic         busy_o;
  win_t         window_o;

  conv_window_feeder #(
    .INPUT_LAYER_HEIGHT(H),
    .KERNEL_WIDTH(K),
    .WORD_SIZE(W)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .data_i(data_i),
    .ready_o(ready_o),
    .start_o(start_o),
    .done_i(done_i),
    .window_o(window_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: every completed column since reset, the partial column,
  // and the number of columns gathered since the last reset/flush.
  col_t         hist[$];
  logic [W-1:0] part[$];
  int           ncols = 0;

  bit gaps     = 0;
  bit junk     = 0;
  bit rst_wait = 0;
  int hold     = 0;

  function automatic win_t exp_win();
    win_t r;
    r = '0;
    for (int w = 0; w < K; w++) begin
      int idx;
      idx = hist.size() - K + w;
      if (idx >= 0) begin
        for (int h = 0; h < H; h++) r[h][w] = hist[idx][h];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [H*K*W-1:0] obs, input logic [H*K*W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    part.delete();
    ncols = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] d, output bit fire);
    col_t c;
    fire = 0;
    part.push_back(d);
    if (part.size() == H) begin
      for (int h = 0; h < H; h++) c[h] = part[h];
      hist.push_back(c);
      part.delete();
      if (ncols < K) ncols++;
      fire = (ncols == K);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    chk("rst_start", start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_window", window_o, 0);
    model_clear();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    valid_i = 1'b0;
    done_i  = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    @(posedge clk_i); #1;
  endtask

  // Walks the layer handshake after the edge that accepted a completing word.
  task automatic layer_cycle();
    valid_i = junk;
    data_i  = 16'hDEAD;
    done_i  = (hold == 0 && !rst_wait);
    @(negedge clk_i);
    chk("st_start", start_o, 1);
    chk("st_ready", ready_o, 0);
    chk("st_busy", busy_o, 1);
    chk("st_window", window_o, exp_win());
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("settle_start", start_o, 0);
    chk("settle_ready", ready_o, 0);
    chk("settle_busy", busy_o, 1);
    chk("settle_window", window_o, exp_win());
    @(posedge clk_i); #1;
    if (rst_wait) begin
      @(negedge clk_i);
      chk("rw_ready", ready_o, 0);
      chk("rw_busy", busy_o, 1);
      @(posedge clk_i); #1;
      reset_i = 1'b1;
      #1;
      chk("rw_start", start_o, 0);
      chk("rw_busy0", busy_o, 0);
      chk("rw_window", window_o, 0);
      model_clear();
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      valid_i = 1'b0;
      done_i  = 1'b1;
      @(negedge clk_i);
      chk("rw_ready1", ready_o, 1);
      chk("rw_nostart", start_o, 0);
      @(posedge clk_i); #1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("wait_ready", ready_o, 0);
      chk("wait_start", start_o, 0);
      chk("wait_busy", busy_o, 1);
      chk("wait_window", window_o, exp_win());
      @(posedge clk_i); #1;
    end
    done_i = 1'b1;
    @(negedge clk_i);
    chk("wdone_ready", ready_o, 0);
    chk("wdone_busy", busy_o, 1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("refill_ready", ready_o, 1);
    chk("refill_busy", busy_o, 0);
    chk("refill_start", start_o, 0);
    chk("refill_window", window_o, exp_win());
    @(posedge clk_i); #1;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    bit fire;
    if (gaps) begin
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        valid_i = 1'b0;
        data_i  = 16'(($urandom));
        @(negedge clk_i);
        chk("gap_ready", ready_o, 1);
        chk("gap_start", start_o, 0);
        @(posedge clk_i); #1;
      end
    end
    valid_i = 1'b1;
    data_i  = d;
    @(negedge clk_i);
    chk("fill_ready", ready_o, 1);
    chk("fill_start", start_o, 0);
    chk("fill_busy", busy_o, 0);
    chk("fill_window", window_o, exp_win());
    @(posedge clk_i); #1;
    model_accept(d, fire);
    if (fire) layer_cycle();
  endtask

  task automatic idle();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_start", start_o, 0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    win_t lit;

    // Reset state
    #1;
    chk("por_start", start_o, 0);
    chk("por_busy", busy_o, 0);
    chk("por_window", window_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("por_ready", ready_o, 1);
    @(posedge clk_i); #1;

    // Warm-up with continuous valid, then a long hold in eWAIT
    hold = 6;
    for (int i = 1; i <= 8; i++) send_word(16'(i));
    for (int h = 0; h < H; h++) begin
      lit[h][0] = 16'(h + 1);
      lit[h][1] = 16'(h + 5);
    end
    chk("warm_literal", window_o, lit);

    // Slide by one column
    hold = 0;
    for (int i = 9; i <= 12; i++) send_word(16'(i));
    for (int h = 0; h < H; h++) begin
      lit[h][0] = 16'(h + 5);
      lit[h][1] = 16'(h + 9);
    end
    chk("slide_literal", window_o, lit);

    // Early done: layer idle the whole time
    for (int i = 13; i <= 20; i++) send_word(16'(i));
    idle();

    // Backpressure and gaps, junk offered while busy
    do_reset();
    gaps = 1; junk = 1; hold = 2;
    for (int i = 1; i <= 8; i++) send_word(16'(i));
    for (int h = 0; h < H; h++) begin
      lit[h][0] = 16'(h + 1);
      lit[h][1] = 16'(h + 5);
    end
    chk("bp_literal", window_o, lit);
    idle();

    // Flush drops the partial column and the fill count
    do_reset();
    gaps = 0; junk = 0; hold = 0;
    for (int i = 1; i <= 6; i++) send_word(16'(i));
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 16'hBEEF;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    part.delete();
    ncols = 0;
    @(negedge clk_i);
    chk("flush_window", window_o, exp_win());
    chk("flush_ready", ready_o, 1);
    @(posedge clk_i); #1;
    for (int i = 20; i <= 27; i++) send_word(16'(i));
    for (int h = 0; h < H; h++) begin
      lit[h][0] = 16'(h + 20);
      lit[h][1] = 16'(h + 24);
    end
    chk("flush_literal", window_o, lit);

    // Random data with gaps and random hold lengths
    gaps = 1;
    for (int c = 0; c < 4; c++) begin
      hold = $urandom_range(0, 3);
      for (int i = 0; i < H; i++) send_word(16'($urandom));
    end
    idle();

    // Reset while waiting for done; no start afterwards until refilled
    gaps = 0; hold = 0; rst_wait = 1;
    for (int i = 0; i < H; i++) send_word(16'($urandom));
    rst_wait = 0;
    for (int i = 0; i < 2 * H; i++) send_word(16'($urandom));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
